// File: rtl/quantize_multiplier_gen.sv
// Purpose: turns float scales (a*b)/c into a Q31 multiplier plus power-of-two shift for the requantizer.
// Latency: 37 cycles from acceptance on the normal path, 1 cycle for error/zero inputs.
// Backpressure: one triple in flight; the result holds in DONE until out_ready, in_ready only in IDLE.
module quantize_multiplier_gen (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        scale_a,
    input  logic [31:0]        scale_b,
    input  logic [31:0]        scale_c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] quantized_multiplier,
    output logic signed [31:0] shift,
    output logic               err,
    output logic               sat
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, NORM, DONE} state_t;

    state_t state, state_nxt;

    // Sign bits are only needed for classification, so only magnitude fields are kept.
    logic [30:0] a_q, b_q, c_q;
    logic [5:0]  cnt;
    logic [57:0] rem;
    logic [57:0] div_d;
    logic [34:0] quo;

    logic        in_err, in_zero;
    logic [23:0] ma, mb, mc;
    logic [47:0] prod;

    logic [1:0]         lead;
    logic [30:0]        m31;
    logic               guard;
    logic [31:0]        qf, qf_n;
    logic signed [11:0] ea, eb, ec, lsel, sh_raw, sh_adj;

    // Negative nonzero or Inf/NaN encodings cannot describe a usable scale.
    function automatic logic is_bad(input logic [31:0] x);
        return (x[31] && (x[30:0] != 31'd0)) || (x[30:23] == 8'hFF);
    endfunction

    assign in_err  = is_bad(scale_a) || is_bad(scale_b) || is_bad(scale_c) || (scale_c[30:23] == 8'd0);
    assign in_zero = (scale_a[30:23] == 8'd0) || (scale_b[30:23] == 8'd0);

    assign ma   = {1'b1, a_q[22:0]};
    assign mb   = {1'b1, b_q[22:0]};
    assign mc   = {1'b1, c_q[22:0]};
    assign prod = {24'd0, ma} * {24'd0, mb};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (in_err || in_zero) ? DONE : MUL;
            end
            MUL:  state_nxt = DIV;
            DIV:  if (cnt == 6'd0) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Normalise the quotient: leading one sits at bit 32..34, keep 31 bits and round half up on the next.
    always_comb begin
        lead  = 2'd0;
        m31   = quo[32:2];
        guard = quo[1];
        if (quo[34]) begin
            lead  = 2'd2;
            m31   = quo[34:4];
            guard = quo[3];
        end else if (quo[33]) begin
            lead  = 2'd1;
            m31   = quo[33:3];
            guard = quo[2];
        end
        qf   = {1'b0, m31} + {31'd0, guard};
        ea   = $signed({4'd0, a_q[30:23]});
        eb   = $signed({4'd0, b_q[30:23]});
        ec   = $signed({4'd0, c_q[30:23]});
        lsel = $signed({10'd0, lead});
        // Ea+Eb-Ec+L-159 with L = 32+lead.
        sh_raw = ea + eb - ec + lsel - 12'sd127;
        // Rounding can carry out to 2^31; renormalise to 2^30 and bump the exponent.
        qf_n   = qf;
        sh_adj = sh_raw;
        if (qf[31]) begin
            qf_n   = 32'h4000_0000;
            sh_adj = sh_raw + 12'sd1;
        end
    end

    // Datapath: capture, multiply, restoring divide and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            cnt   <= '0;
            rem   <= '0;
            div_d <= '0;
            quo   <= '0;
            quantized_multiplier <= '0;
            shift <= '0;
            err   <= 1'b0;
            sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= scale_a[30:0];
                        b_q <= scale_b[30:0];
                        c_q <= scale_c[30:0];
                        quantized_multiplier <= '0;
                        shift <= '0;
                        sat   <= 1'b0;
                        err   <= in_err;
                    end
                end
                MUL: begin
                    rem   <= {prod, 10'd0};
                    div_d <= {mc, 34'd0};
                    quo   <= '0;
                    cnt   <= 6'd34;
                end
                DIV: begin
                    // Quotient < 2^35 guarantees rem < 2*div_d, so one trial subtract per bit suffices.
                    if (rem >= div_d) begin
                        rem <= rem - div_d;
                        quo <= {quo[33:0], 1'b1};
                    end else begin
                        quo <= {quo[33:0], 1'b0};
                    end
                    div_d <= div_d >> 1;
                    if (cnt != 6'd0) cnt <= cnt - 6'd1;
                end
                NORM: begin
                    err <= 1'b0;
                    if (sh_adj > 12'sd30) begin
                        quantized_multiplier <= 32'sh7FFF_FFFF;
                        shift <= 32'sd30;
                        sat   <= 1'b1;
                    end else if (sh_adj < -12'sd31) begin
                        quantized_multiplier <= '0;
                        shift <= '0;
                        sat   <= 1'b0;
                    end else begin
                        quantized_multiplier <= $signed(qf_n);
                        shift <= {{20{sh_adj[11]}}, sh_adj};
                        sat   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quantize_multiplier_gen.sv
// Directed checks of the scale-to-multiplier generator: vector table plus
// backpressure and mid-division reset sequences.
module tb_quantize_multiplier_gen;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        scale_a, scale_b, scale_c;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] quantized_multiplier;
    logic signed [31:0] shift;
    logic               err, sat;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a, b, c;
        logic [31:0] mult, sh;
        logic        err, sat;
        int          lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    quantize_multiplier_gen dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .scale_a              (scale_a),
        .scale_b              (scale_b),
        .scale_c              (scale_c),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .quantized_multiplier (quantized_multiplier),
        .shift                (shift),
        .err                  (err),
        .sat                  (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, b, c, mult, sh, input logic e, s, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.mult = mult; v.sh = sh; v.err = e; v.sat = s; v.lat = lat;
        return v;
    endfunction

    // Present a triple, measure edges to out_valid, check the result, then complete the handshake.
    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        scale_a = v.a; scale_b = v.b; scale_c = v.c;
        in_valid = 1'b1;
        chk($sformatf("v%0d_in_ready_idle", idx), {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        scale_a = $urandom; scale_b = $urandom; scale_c = $urandom;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 100);
        chk($sformatf("v%0d_latency", idx), n, v.lat);
        chk($sformatf("v%0d_mult", idx), quantized_multiplier, v.mult);
        chk($sformatf("v%0d_shift", idx), shift, v.sh);
        chk($sformatf("v%0d_err_sat", idx), {30'd0, err, sat}, {30'd0, v.err, v.sat});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d_release", idx), {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    localparam logic [31:0] ONE = 32'h3F80_0000;

    initial begin
        int n;
        logic [31:0] hm, hs;

        vecs[0]  = mk(ONE,          ONE,          ONE,          32'h4000_0000, 32'd1,   0, 0, 37);
        vecs[1]  = mk(32'h3F00_0000, 32'h3E80_0000, 32'h4000_0000, 32'h4000_0000, -32'sd3, 0, 0, 37);
        vecs[2]  = mk(ONE,          ONE,          32'h4040_0000, 32'h5555_5555, -32'sd1, 0, 0, 37);
        vecs[3]  = mk(32'h3F80_1000, 32'h3F80_0008, ONE,          32'h4008_0401, 32'd1,   0, 0, 37);
        vecs[4]  = mk(32'h3F80_1001, 32'h3F80_07FF, 32'h3F80_1801, 32'h4000_0000, 32'd1,   0, 0, 37);
        vecs[5]  = mk(32'h7180_0000, ONE,          ONE,          32'h7FFF_FFFF, 32'd30,  0, 1, 37);
        vecs[6]  = mk(32'h0D80_0000, ONE,          ONE,          32'h0,         32'd0,   0, 0, 37);
        vecs[7]  = mk(32'h4E00_0000, ONE,          ONE,          32'h4000_0000, 32'd30,  0, 0, 37);
        vecs[8]  = mk(32'h4E80_0000, ONE,          ONE,          32'h7FFF_FFFF, 32'd30,  0, 1, 37);
        vecs[9]  = mk(32'h2F80_0000, ONE,          ONE,          32'h4000_0000, -32'sd31, 0, 0, 37);
        vecs[10] = mk(32'h2F00_0000, ONE,          ONE,          32'h0,         32'd0,   0, 0, 37);
        vecs[11] = mk(ONE,          ONE,          32'h0000_0000, 32'h0,         32'd0,   1, 0, 1);
        vecs[12] = mk(ONE,          ONE,          32'h7FC0_0000, 32'h0,         32'd0,   1, 0, 1);
        vecs[13] = mk(32'hBF80_0000, ONE,          ONE,          32'h0,         32'd0,   1, 0, 1);
        vecs[14] = mk(32'h0000_0000, ONE,          ONE,          32'h0,         32'd0,   0, 0, 1);
        vecs[15] = mk(32'h8000_0000, ONE,          ONE,          32'h0,         32'd0,   0, 0, 1);
        vecs[16] = mk(ONE,          32'h0040_0000, ONE,          32'h0,         32'd0,   0, 0, 1);
        vecs[17] = mk(ONE,          ONE,          32'h0040_0000, 32'h0,         32'd0,   1, 0, 1);
        vecs[18] = mk(32'h7F80_0000, ONE,          ONE,          32'h0,         32'd0,   1, 0, 1);

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        scale_a = '0; scale_b = '0; scale_c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {29'd0, out_valid, err, sat}, 32'd0);
        chk("reset_mult", quantized_multiplier, 32'd0);
        chk("reset_shift", shift, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Backpressure: result must hold for 10 cycles while the inputs wiggle.
        @(negedge clk);
        scale_a = 32'h3F80_1000; scale_b = 32'h3F80_0008; scale_c = ONE;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 100);
        chk("bp_latency", n, 37);
        hm = 32'h4008_0401; hs = 32'd1;
        for (int k = 0; k < 10; k++) begin
            scale_a = $urandom; scale_b = $urandom; scale_c = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_hold%0d", k), {quantized_multiplier[31:2], out_valid, in_ready},
                {hm[31:2], 1'b1, 1'b0});
        end
        chk("bp_shift", shift, hs);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release", {30'd0, out_valid, in_ready}, 32'd1);

        // Reset in the middle of the division: that triple must never produce a result.
        scale_a = ONE; scale_b = ONE; scale_c = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("middiv_busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("middiv_in_ready", {31'd0, in_ready}, 32'd1);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("middiv_no_result", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
